// File: rtl/rd53b_command_process.sv
// RD53B command stream decoder: symbol decode, chip-ID filtering, command strobes and CAL injection timing.
// Optional CAL_aux generation is enabled by defining CAL_AUX_EN; otherwise CAL_aux is tied low.
module rd53b_command_process (
   input  logic        clk80,
   input  logic        reset,
   input  logic        data_in_valid,
   input  logic [7:0]  data_in,
   input  logic [3:0]  chip_id,
   output logic        clear,
   output logic        pulse,
   output logic        cal,
   output logic        wrreg,
   output logic        rdreg,
   output logic        sync,
   output logic [15:0] data_out,
   output logic        data_out_valid,
   output logic [8:0]  register_address,
   output logic        register_address_valid,
   output logic        CAL_edge,
   output logic        CAL_aux
);

   typedef enum logic [1:0] {IDLE, SYNC2, ID, DATA} state_t;
   typedef enum logic [2:0] {CMD_CLEAR, CMD_PULSE, CMD_CAL, CMD_RDREG, CMD_WRREG} cmd_t;

   state_t      state_q;
   cmd_t        cmd_q, newCmd_d;
   logic        match_q;
   logic [2:0]  cnt_q;
   logic [23:0] payload_q;
   logic [28:0] payload_d;
   logic        symIsData, symIsCmd, idMatch, complete, fire, calFire;
   logic [4:0]  symVal;
   logic [2:0]  payLen;
   logic        clear_q, pulse_q, cal_q, wrreg_q, rdreg_q, sync_q, dataValid_q, addrValid_q;
   logic [15:0] dataOut_q;
   logic [8:0]  addr_q;
   logic        edgeOn_q, edgePend_q, edgeMode_q;
   logic [3:0]  edgeDly_q;
   logic [4:0]  edgeWidth_q, edgeCnt_q;

   always_comb begin
      symIsData = 1'b1;
      symVal    = 5'd0;
      case (data_in)
         8'h6A: symVal = 5'd0;   8'h6C: symVal = 5'd1;   8'h71: symVal = 5'd2;   8'h72: symVal = 5'd3;
         8'h74: symVal = 5'd4;   8'h8B: symVal = 5'd5;   8'h8D: symVal = 5'd6;   8'h8E: symVal = 5'd7;
         8'h93: symVal = 5'd8;   8'h95: symVal = 5'd9;   8'h96: symVal = 5'd10;  8'h99: symVal = 5'd11;
         8'h9A: symVal = 5'd12;  8'h9C: symVal = 5'd13;  8'hA3: symVal = 5'd14;  8'hA5: symVal = 5'd15;
         8'hA6: symVal = 5'd16;  8'hA9: symVal = 5'd17;  8'h59: symVal = 5'd18;  8'hAC: symVal = 5'd19;
         8'hB1: symVal = 5'd20;  8'hB2: symVal = 5'd21;  8'hB4: symVal = 5'd22;  8'hC3: symVal = 5'd23;
         8'hC5: symVal = 5'd24;  8'hC6: symVal = 5'd25;  8'hC9: symVal = 5'd26;  8'hCA: symVal = 5'd27;
         8'hCC: symVal = 5'd28;  8'hD1: symVal = 5'd29;  8'hD2: symVal = 5'd30;  8'hD4: symVal = 5'd31;
         default: symIsData = 1'b0;
      endcase
   end

   always_comb begin
      symIsCmd = 1'b1;
      newCmd_d = CMD_CLEAR;
      case (data_in)
         8'h5A: newCmd_d = CMD_CLEAR;
         8'h5C: newCmd_d = CMD_PULSE;
         8'h63: newCmd_d = CMD_CAL;
         8'h65: newCmd_d = CMD_RDREG;
         8'h66: newCmd_d = CMD_WRREG;
         8'hAA, 8'h81: newCmd_d = CMD_CLEAR;
         default: symIsCmd = 1'b0;
      endcase
   end

   always_comb begin
      payLen = 3'd0;
      case (cmd_q)
         CMD_CAL:   payLen = 3'd3;
         CMD_RDREG: payLen = 3'd2;
         CMD_WRREG: payLen = 3'd6;
         default:   payLen = 3'd0;
      endcase
   end

   // Only the low four bits of WrReg D0 carry address, so the shift register keeps 24 bits plus the live symbol.
   assign payload_d = {payload_q, symVal};
   assign idMatch   = symVal[4] | (symVal[3:0] == chip_id);
   assign complete  = data_in_valid & symIsData &
                      (((state_q == ID) & (payLen == 3'd0)) | ((state_q == DATA) & (cnt_q == payLen - 3'd1)));
   assign fire      = complete & ((state_q == ID) ? idMatch : match_q);
   assign calFire   = fire & (cmd_q == CMD_CAL);

   always_ff @(posedge clk80 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;  cmd_q <= CMD_CLEAR;  match_q <= 1'b0;  cnt_q <= 3'd0;  payload_q <= '0;
         {clear_q, pulse_q, cal_q, wrreg_q, rdreg_q, sync_q, dataValid_q, addrValid_q} <= '0;
         dataOut_q <= '0;
         addr_q    <= '0;
      end else begin
         {clear_q, pulse_q, cal_q, wrreg_q, rdreg_q, sync_q, dataValid_q, addrValid_q} <= '0;
         if (data_in_valid) begin
            if ((state_q == SYNC2) && (data_in == 8'h7E)) begin
               sync_q  <= 1'b1;
               state_q <= IDLE;
            end else if (symIsCmd) begin
               cmd_q <= newCmd_d;
               case (data_in)
                  8'hAA:   state_q <= IDLE;
                  8'h81:   state_q <= SYNC2;
                  default: state_q <= ID;
               endcase
            end else if (!symIsData) begin
               state_q <= IDLE;
            end else begin
               case (state_q)
                  ID: begin
                     match_q <= idMatch;
                     cnt_q   <= 3'd0;
                     state_q <= (payLen == 3'd0) ? IDLE : DATA;
                  end
                  DATA: begin
                     payload_q <= payload_d[23:0];
                     cnt_q     <= cnt_q + 3'd1;
                     if (cnt_q == payLen - 3'd1) state_q <= IDLE;
                  end
                  default: state_q <= IDLE;
               endcase
               if (fire) begin
                  case (cmd_q)
                     CMD_CLEAR: clear_q <= 1'b1;
                     CMD_PULSE: pulse_q <= 1'b1;
                     CMD_CAL:   cal_q   <= 1'b1;
                     CMD_RDREG: begin
                        rdreg_q     <= 1'b1;
                        addrValid_q <= 1'b1;
                        addr_q      <= payload_d[8:0];
                     end
                     CMD_WRREG: begin
                        wrreg_q     <= 1'b1;
                        addrValid_q <= 1'b1;
                        dataValid_q <= 1'b1;
                        addr_q      <= payload_d[28:20];
                        dataOut_q   <= {payload_d[19:5], payload_d[4]};
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   // A new Cal drops CAL_edge during its strobe cycle and restarts the delay countdown.
   always_ff @(posedge clk80 or negedge reset) begin
      if (!reset) begin
         edgeOn_q <= 1'b0;  edgePend_q <= 1'b0;  edgeMode_q <= 1'b0;
         edgeDly_q <= 4'd0;  edgeWidth_q <= 5'd0;  edgeCnt_q <= 5'd0;
      end else if (calFire) begin
         edgeOn_q    <= 1'b0;
         edgePend_q  <= 1'b1;
         edgeMode_q  <= payload_d[14];
         edgeDly_q   <= payload_d[13:10];
         edgeWidth_q <= payload_d[9:5];
      end else if (edgePend_q) begin
         if (edgeDly_q == 4'd0) begin
            edgePend_q <= 1'b0;
            if (!edgeMode_q || (edgeWidth_q != 5'd0)) begin
               edgeOn_q  <= 1'b1;
               edgeCnt_q <= edgeWidth_q - 5'd1;
            end
         end else begin
            edgeDly_q <= edgeDly_q - 4'd1;
         end
      end else if (edgeOn_q && edgeMode_q) begin
         if (edgeCnt_q == 5'd0) edgeOn_q <= 1'b0;
         else                   edgeCnt_q <= edgeCnt_q - 5'd1;
      end
   end

`ifdef CAL_AUX_EN
   logic       auxPend_q, auxLevel_q, auxOut_q;
   logic [3:0] auxDly_q;

   // A pending level change due on the same edge as a new Cal still lands before the timer restarts.
   always_ff @(posedge clk80 or negedge reset) begin
      if (!reset) begin
         auxPend_q <= 1'b0;  auxLevel_q <= 1'b0;  auxOut_q <= 1'b0;  auxDly_q <= 4'd0;
      end else begin
         if (auxPend_q) begin
            if (auxDly_q == 4'd0) begin
               auxOut_q  <= auxLevel_q;
               auxPend_q <= 1'b0;
            end else begin
               auxDly_q <= auxDly_q - 4'd1;
            end
         end
         if (calFire) begin
            auxPend_q  <= 1'b1;
            auxDly_q   <= payload_d[3:0];
            auxLevel_q <= payload_d[4];
         end
      end
   end

   assign CAL_aux = auxOut_q;
`else
   assign CAL_aux = 1'b0;
`endif

   assign clear                  = clear_q;
   assign pulse                  = pulse_q;
   assign cal                    = cal_q;
   assign wrreg                  = wrreg_q;
   assign rdreg                  = rdreg_q;
   assign sync                   = sync_q;
   assign data_out               = dataOut_q;
   assign data_out_valid         = dataValid_q;
   assign register_address       = addr_q;
   assign register_address_valid = addrValid_q;
   assign CAL_edge               = edgeOn_q;

endmodule

// File: tb/tb_rd53b_command_process.sv
// Self-checking bench for rd53b_command_process: directed vector table, hand sequences and
// randomized command streams checked against a command-level reference model.
module tb_rd53b_command_process;

   logic        clk80 = 1'b0;
   logic        reset;
   logic        data_in_valid;
   logic [7:0]  data_in;
   logic [3:0]  chip_id;
   logic        clear, pulse, cal, wrreg, rdreg, sync;
   logic [15:0] data_out;
   logic        data_out_valid;
   logic [8:0]  register_address;
   logic        register_address_valid;
   logic        CAL_edge, CAL_aux;

   rd53b_command_process dut (
      .clk80(clk80), .reset(reset), .data_in_valid(data_in_valid), .data_in(data_in), .chip_id(chip_id),
      .clear(clear), .pulse(pulse), .cal(cal), .wrreg(wrreg), .rdreg(rdreg), .sync(sync),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .register_address(register_address), .register_address_valid(register_address_valid),
      .CAL_edge(CAL_edge), .CAL_aux(CAL_aux)
   );

   always #6 clk80 = ~clk80;

`ifdef CAL_AUX_EN
   localparam bit AuxEn = 1'b1;
`else
   localparam bit AuxEn = 1'b0;
`endif

   typedef struct {
      bit          v;
      logic [7:0]  sym;
      logic [3:0]  chip;
      logic [5:0]  strobes;
      logic [8:0]  adx;
      logic [15:0] dat;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] dataSym [32] = '{8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
                                8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
                                8'hA6, 8'hA9, 8'h59, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
                                8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};
   logic [7:0] cmdList [7] = '{8'h5A, 8'h5C, 8'h63, 8'h65, 8'h66, 8'hAA, 8'h81};

   // Reference model state: the command being collected and the values gathered so far.
   logic [7:0]  mCmd;
   int          mSyms[$];
   bit          mMatch, mSyncPend;
   logic [5:0]  expStrobe;
   logic [8:0]  expAddr;
   logic [15:0] expData;
   bit          calValid;
   int          cS, cMode, cDly, cW, aLvl, aDly, auxPrev;

   function automatic int symValue(input logic [7:0] s);
      for (int i = 0; i < 32; i++) if (dataSym[i] == s) return i;
      return -1;
   endfunction

   function automatic int payloadLen(input logic [7:0] c);
      case (c)
         8'h63:   return 3;
         8'h65:   return 2;
         8'h66:   return 6;
         default: return 0;
      endcase
   endfunction

   function automatic bit modelEdge(input int c);
      int k;
      if (!calValid) return 1'b0;
      k = c - cS;
      if (k < cDly + 1) return 1'b0;
      if (cMode == 0) return 1'b1;
      return k <= cDly + cW;
   endfunction

   function automatic bit modelAux(input int c);
      if (!calValid || !AuxEn) return 1'b0;
      return (c - cS >= aDly + 1) ? (aLvl != 0) : (auxPrev != 0);
   endfunction

   task automatic resetModel();
      mCmd = 8'h00;  mSyms.delete();  mMatch = 1'b0;  mSyncPend = 1'b0;
      expStrobe = '0;  expAddr = '0;  expData = '0;
      calValid = 1'b0;  auxPrev = 0;
   endtask

   task automatic modelComplete();
      case (mCmd)
         8'h5A: expStrobe[5] = 1'b1;
         8'h5C: expStrobe[4] = 1'b1;
         8'h63: begin
            auxPrev  = int'(modelAux(cyc));
            calValid = 1'b1;  cS = cyc;
            cMode = mSyms[1] / 16;  cDly = mSyms[1] % 16;  cW = mSyms[2];
            aLvl  = mSyms[3] / 16;  aDly = mSyms[3] % 16;
            expStrobe[3] = 1'b1;
         end
         8'h66: begin
            expStrobe[2] = 1'b1;
            expAddr = 9'((mSyms[1] % 16) * 32 + mSyms[2]);
            expData = 16'(mSyms[3] * 2048 + mSyms[4] * 64 + mSyms[5] * 2 + mSyms[6] / 16);
         end
         8'h65: begin
            expStrobe[1] = 1'b1;
            expAddr = 9'((mSyms[1] % 16) * 32 + mSyms[2]);
         end
         default: ;
      endcase
   endtask

   task automatic modelSymbol(input logic [7:0] s);
      int v;
      v = symValue(s);
      if (mSyncPend) begin
         mSyncPend = 1'b0;
         if (s == 8'h7E) begin
            expStrobe[0] = 1'b1;
            return;
         end
      end
      if (s inside {8'h5A, 8'h5C, 8'h63, 8'h65, 8'h66, 8'hAA, 8'h81}) begin
         mSyms.delete();
         mCmd      = (s inside {8'h5A, 8'h5C, 8'h63, 8'h65, 8'h66}) ? s : 8'h00;
         mSyncPend = (s == 8'h81);
         return;
      end
      if (v < 0) begin
         mCmd = 8'h00;
         return;
      end
      if (mCmd == 8'h00) return;
      if (mSyms.size() == 0) mMatch = (v >= 16) || ((v % 16) == int'(chip_id));
      mSyms.push_back(v);
      if (mSyms.size() == payloadLen(mCmd) + 1) begin
         if (mMatch) modelComplete();
         mCmd = 8'h00;
         mSyms.delete();
      end
   endtask

   task automatic checkOutput(input string name);
      logic [34:0] act, req;
      act = {clear, pulse, cal, wrreg, rdreg, sync, data_out_valid, register_address_valid,
             CAL_edge, CAL_aux, register_address, data_out};
      req = {expStrobe, expStrobe[2], expStrobe[2] | expStrobe[1], modelEdge(cyc), modelAux(cyc),
             expAddr, expData};
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [7:0] s, input string name);
      data_in_valid = v;
      data_in       = s;
      @(posedge clk80);
      #1;
      cyc++;
      expStrobe = '0;
      if (v) modelSymbol(s);
      checkOutput(name);
   endtask

   task automatic applyReset();
      reset = 1'b0;
      #1;
      resetModel();
      checkOutput("reset-async");
      repeat (2) @(posedge clk80);
      #1;
      cyc += 2;
      checkOutput("reset-held");
      reset = 1'b1;
   endtask

   task automatic sendRand(input logic [7:0] s);
      logic [7:0] sym;
      sym = s;
      if ($urandom_range(0, 4) == 0) applyStimulus(1'b0, 8'($urandom), "rand-idle");
      if ($urandom_range(0, 19) == 0) sym = 8'($urandom);
      applyStimulus(1'b1, sym, "rand");
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t       vecs [36];
      logic [7:0] c;
      int         id, n;

      data_in_valid = 1'b0;
      data_in       = 8'h00;
      chip_id       = 4'h0;
      applyReset();

      vecs = '{
         '{1'b0, 8'h5A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b0, 8'h5A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b0, 8'h5A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h5A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'h0, 6'b100000, 9'h000, 16'h0000},
         '{1'b1, 8'h5C, 4'hF, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'hF, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h5C, 4'h4, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h74, 4'h4, 6'b010000, 9'h000, 16'h0000},
         '{1'b1, 8'h66, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'hA6, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h8B, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'hD4, 4'h0, 6'b000000, 9'h000, 16'h0000},
         '{1'b1, 8'h6A, 4'h0, 6'b000100, 9'h000, 16'h817E},
         '{1'b1, 8'h65, 4'h0, 6'b000000, 9'h000, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h000, 16'h817E},
         '{1'b1, 8'h6C, 4'h0, 6'b000000, 9'h000, 16'h817E},
         '{1'b1, 8'h8B, 4'h0, 6'b000010, 9'h025, 16'h817E},
         '{1'b1, 8'h81, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b0, 8'h7E, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b0, 8'h7E, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b0, 8'h7E, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h7E, 4'h0, 6'b000001, 9'h025, 16'h817E},
         '{1'b1, 8'h81, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h66, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h5A, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b100000, 9'h025, 16'h817E},
         '{1'b1, 8'h5A, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h00, 4'h0, 6'b000000, 9'h025, 16'h817E},
         '{1'b1, 8'h6A, 4'h0, 6'b000000, 9'h025, 16'h817E}
      };

      for (int i = 0; i < 36; i++) begin
         chip_id = vecs[i].chip;
         applyStimulus(vecs[i].v, vecs[i].sym, "vec-model");
         checkValue($sformatf("vec%0d", i),
                    {1'b0, {clear, pulse, cal, wrreg, rdreg, sync}, register_address, data_out},
                    {1'b0, vecs[i].strobes, vecs[i].adx, vecs[i].dat});
      end

      // Cal pulse mode, delay 6, width 3, aux level 1 after delay 2.
      chip_id = 4'h0;
      applyStimulus(1'b1, 8'h63, "cal-cmd");
      applyStimulus(1'b1, 8'h6A, "cal-id");
      applyStimulus(1'b1, 8'hB4, "cal-d0");
      applyStimulus(1'b1, 8'h72, "cal-d1");
      applyStimulus(1'b1, 8'h59, "cal-d2");
      checkValue("cal-strobe", {31'd0, cal}, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 8'h00, "cal-wait");
         checkValue($sformatf("cal-edge-k%0d", k), {31'd0, CAL_edge}, {31'd0, (k >= 7 && k <= 9)});
         checkValue($sformatf("cal-aux-k%0d", k), {31'd0, CAL_aux}, {31'd0, AuxEn && (k >= 3)});
      end

      // Level mode interrupted by a zero-width pulse-mode Cal.
      applyStimulus(1'b1, 8'h63, "lvl-cmd");
      applyStimulus(1'b1, 8'hA6, "lvl-id");
      applyStimulus(1'b1, 8'h71, "lvl-d0");
      applyStimulus(1'b1, 8'h6A, "lvl-d1");
      applyStimulus(1'b1, 8'h6A, "lvl-d2");
      repeat (6) applyStimulus(1'b0, 8'h00, "lvl-wait");
      checkValue("lvl-edge-held", {31'd0, CAL_edge}, 32'd1);
      applyStimulus(1'b1, 8'h63, "w0-cmd");
      applyStimulus(1'b1, 8'h6A, "w0-id");
      applyStimulus(1'b1, 8'hA6, "w0-d0");
      applyStimulus(1'b1, 8'h6A, "w0-d1");
      applyStimulus(1'b1, 8'h6A, "w0-d2");
      repeat (4) applyStimulus(1'b0, 8'h00, "w0-wait");
      checkValue("w0-no-pulse", {31'd0, CAL_edge}, 32'd0);

      // Reset in the middle of a WrReg discards it.
      applyStimulus(1'b1, 8'h66, "rst-cmd");
      applyStimulus(1'b1, 8'h6A, "rst-id");
      applyStimulus(1'b1, 8'h6A, "rst-d0");
      applyStimulus(1'b1, 8'hA6, "rst-d1");
      applyReset();
      applyStimulus(1'b1, 8'h8B, "rst-d2");
      applyStimulus(1'b1, 8'hD4, "rst-d3");
      applyStimulus(1'b1, 8'h6A, "rst-d4");
      applyStimulus(1'b1, 8'h6A, "rst-d5");
      checkValue("rst-no-wrreg", {15'd0, wrreg, data_out}, 32'd0);

      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 9) == 0) chip_id = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) applyReset();
         c = cmdList[$urandom_range(0, 6)];
         sendRand(c);
         if (c == 8'h81) begin
            sendRand(($urandom_range(0, 3) != 0) ? 8'h7E : 8'($urandom));
         end else if (c != 8'hAA) begin
            case ($urandom_range(0, 2))
               0:       id = int'($urandom_range(16, 31));
               1:       id = int'(chip_id);
               default: id = int'($urandom_range(0, 31));
            endcase
            sendRand(dataSym[id]);
            n = payloadLen(c);
            for (int i = 0; i < n; i++) sendRand(dataSym[$urandom_range(0, 31)]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
